// File: rtl/imem_boot_loader.sv
// imem_boot_loader: byte-stream boot loader for a 64 x 32-bit instruction memory.
// It assembles bytes into words, writes them through a registered port, and holds
// the core in reset until the whole program is loaded.
// Ports: clk, rst (sync, active-high); in_valid/in_data/in_ready byte handshake;
// imem_we/imem_addr/imem_wdata write port; cpu_rst, busy, done, err status.
// Optional feature macro: IMEM_BOOT_CHECKSUM_EN adds a trailing checksum byte.
module imem_boot_loader #(
  parameter int DEPTH = 64,
  parameter int AW    = 6
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  input  logic [7:0]    in_data,
  output logic          in_ready,
  output logic          imem_we,
  output logic [AW-1:0] imem_addr,
  output logic [31:0]   imem_wdata,
  output logic          cpu_rst,
  output logic          busy,
  output logic          done,
  output logic          err
);

  typedef enum logic [2:0] {
    HDR0 = 3'd0,
    HDR1 = 3'd1,
    DATA = 3'd2,
    FIN  = 3'd3,
    DONE = 3'd4,
    ERR  = 3'd5
`ifdef IMEM_BOOT_CHECKSUM_EN
    ,
    CSUM = 3'd6
`endif
  } state_t;

  state_t        state;
  state_t        state_nx;

  logic [7:0]    n_hi;
  logic [15:0]   n;
  logic [15:0]   n_full;
  logic [AW-1:0] widx;
  logic [1:0]    bcnt;
  logic [23:0]   asm_q;
  logic          busy_q;
  logic          accept;
  logic          hdr_bad;
  logic          last_word;
`ifdef IMEM_BOOT_CHECKSUM_EN
  logic [7:0]    sum;
`endif

  // Ready depends on state only, so accept never loops back into itself.
  assign in_ready = !(state == FIN || state == DONE || state == ERR);
  assign accept   = in_valid && in_ready;

  // Range check on the full 16-bit count, never a truncated copy.
  assign n_full  = {n_hi, in_data};
  assign hdr_bad = (n_full == 16'd0) || (n_full > 16'(DEPTH));

  // n >= 1 once in DATA, so n-1 never underflows there.
  assign last_word = (16'(widx) == (n - 16'd1));

  assign cpu_rst = (state != DONE);
  assign done    = (state == DONE);
  assign err     = (state == ERR);
  assign busy    = busy_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= HDR0;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      HDR0: begin
        if (in_valid) state_nx = HDR1;
      end
      HDR1: begin
        if (in_valid) state_nx = hdr_bad ? ERR : DATA;
      end
      DATA: begin
        if (in_valid && bcnt == 2'd3 && last_word) begin
`ifdef IMEM_BOOT_CHECKSUM_EN
          state_nx = CSUM;
`else
          state_nx = FIN;
`endif
        end
      end
`ifdef IMEM_BOOT_CHECKSUM_EN
      CSUM: begin
        if (in_valid) state_nx = (in_data == sum) ? FIN : ERR;
      end
`endif
      FIN:  state_nx = DONE;
      DONE: state_nx = DONE;
      ERR:  state_nx = ERR;
      default: state_nx = HDR0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      n_hi       <= 8'd0;
      n          <= 16'd0;
      widx       <= '0;
      bcnt       <= 2'd0;
      asm_q      <= 24'd0;
      busy_q     <= 1'b0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= 32'd0;
`ifdef IMEM_BOOT_CHECKSUM_EN
      sum        <= 8'd0;
`endif
    end else begin
      imem_we <= 1'b0;
      if (accept && state == HDR0) begin
        n_hi   <= in_data;
        busy_q <= 1'b1;
      end
      if (accept && state == HDR1) begin
        n <= n_full;
      end
      if (accept && state == DATA) begin
        bcnt  <= bcnt + 2'd1;
        asm_q <= {asm_q[15:0], in_data};
`ifdef IMEM_BOOT_CHECKSUM_EN
        sum   <= sum + in_data;
`endif
        if (bcnt == 2'd3) begin
          imem_we    <= 1'b1;
          imem_addr  <= widx;
          imem_wdata <= {asm_q, in_data};
          // Wraps to 0 after word DEPTH-1; unused past the last word.
          widx       <= widx + AW'(1);
        end
      end
      if (state_nx == DONE || state_nx == ERR) begin
        busy_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_imem_boot_loader.sv
// tb_imem_boot_loader: directed self-checking bench for imem_boot_loader.
// Works with or without IMEM_BOOT_CHECKSUM_EN defined.
module tb_imem_boot_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        imem_we;
  logic [5:0]  imem_addr;
  logic [31:0] imem_wdata;
  logic        cpu_rst;
  logic        busy;
  logic        done;
  logic        err;

  int errors = 0;
  int checks = 0;
  int wr_cnt = 0;
  int rdrop  = 0;
  logic [5:0]  wr_addr [0:127];
  logic [31:0] wr_data [0:127];
  logic [7:0]  csum;

  imem_boot_loader #(.DEPTH(64), .AW(6)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .cpu_rst    (cpu_rst),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (imem_we === 1'b1) begin
      if (wr_cnt < 128) begin
        wr_addr[wr_cnt] = imem_addr;
        wr_data[wr_cnt] = imem_wdata;
      end
      wr_cnt++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    in_valid = 1'b1;
    in_data  = b;
    if (in_ready !== 1'b1) rdrop++;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    in_data  = 8'($urandom);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    rst    = 1'b0;
    wr_cnt = 0;
    rdrop  = 0;
    csum   = 8'd0;
  endtask

  task automatic send_pay(input logic [7:0] b);
    csum = csum + b;
    send(b);
  endtask

  task automatic load3(input bit gaps);
    logic [31:0] w [0:2];
    w[0] = 32'h12345678;
    w[1] = 32'h9ABCDEF0;
    w[2] = 32'h0BADF00D;
    do_reset();
    send(8'h00);
    if (gaps) idle($urandom_range(0, 3));
    send(8'h03);
    for (int i = 0; i < 3; i++) begin
      for (int j = 3; j >= 0; j--) begin
        if (gaps) idle($urandom_range(0, 3));
        send_pay(w[i][8*j +: 8]);
      end
    end
`ifdef IMEM_BOOT_CHECKSUM_EN
    if (gaps) idle($urandom_range(0, 3));
    send(csum);
`endif
    idle(2);
    chk(gaps ? "gap_cnt" : "nogap_cnt", 32'(wr_cnt), 32'd3);
    for (int i = 0; i < 3; i++) begin
      chk(gaps ? "gap_addr" : "nogap_addr", 32'(wr_addr[i]), 32'(i));
      chk(gaps ? "gap_data" : "nogap_data", wr_data[i], w[i]);
    end
    chk(gaps ? "gap_done" : "nogap_done", 32'(done), 32'd1);
  endtask

  initial begin
    int bad;
    logic [31:0] ew;
    rst      = 1'b1;
    in_valid = 1'b0;
    in_data  = 8'd0;
    csum     = 8'd0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_flags", 32'({in_ready, imem_we, cpu_rst, busy, done, err}),
        32'b101000);
    chk("rst_addr", 32'(imem_addr), 32'd0);
    chk("rst_wdata", imem_wdata, 32'd0);
    rst = 1'b0;

    // N=1, single word
    do_reset();
    send(8'h00);
    send(8'h01);
    chk("t1_hdr_busy", 32'({busy, in_ready, cpu_rst}), 32'b111);
    send_pay(8'h20);
    send_pay(8'h08);
    send_pay(8'h00);
    send_pay(8'h05);
    chk("t1_we", 32'(imem_we), 32'd1);
    chk("t1_addr", 32'(imem_addr), 32'd0);
    chk("t1_wdata", imem_wdata, 32'h20080005);
`ifdef IMEM_BOOT_CHECKSUM_EN
    chk("t1_csum_st", 32'({in_ready, cpu_rst, done}), 32'b110);
    send(csum);
    chk("t1_fin", 32'({in_ready, cpu_rst, done, imem_we}), 32'b0100);
`else
    chk("t1_fin", 32'({in_ready, cpu_rst, done, busy}), 32'b0101);
`endif
    idle(1);
    chk("t1_done", 32'({done, cpu_rst, err, busy, in_ready, imem_we}),
        32'b100000);
    chk("t1_wcnt", 32'(wr_cnt), 32'd1);
    in_valid = 1'b1;
    in_data  = 8'hFF;
    repeat (3) begin @(posedge clk); #1; end
    in_valid = 1'b0;
    chk("t1_ignore", 32'({done, cpu_rst}), 32'b10);
    chk("t1_ignore_cnt", 32'(wr_cnt), 32'd1);

    // N=64, back-to-back
    do_reset();
    send(8'h00);
    send(8'h40);
    for (int i = 0; i < 64; i++)
      for (int j = 0; j < 4; j++)
        send_pay(8'(4 * i + j));
`ifdef IMEM_BOOT_CHECKSUM_EN
    send(csum);
`endif
    chk("t2_ready", 32'(rdrop), 32'd0);
    idle(1);
    chk("t2_done", 32'({done, err, cpu_rst}), 32'b100);
    chk("t2_wcnt", 32'(wr_cnt), 32'd64);
    bad = 0;
    for (int i = 0; i < 64; i++) begin
      ew = {8'(4 * i), 8'(4 * i + 1), 8'(4 * i + 2), 8'(4 * i + 3)};
      if (wr_addr[i] !== 6'(i) || wr_data[i] !== ew) bad++;
    end
    chk("t2_words", 32'(bad), 32'd0);

    // Illegal headers
    do_reset();
    send(8'h00);
    send(8'h00);
    chk("t3_zero", 32'({err, in_ready, cpu_rst, busy, done}), 32'b10100);
    in_valid = 1'b1;
    in_data  = 8'h01;
    repeat (3) begin @(posedge clk); #1; end
    in_valid = 1'b0;
    chk("t3_zero_hold", 32'({err, in_ready}), 32'b10);
    chk("t3_zero_we", 32'(wr_cnt), 32'd0);
    do_reset();
    send(8'h00);
    send(8'h41);
    chk("t3_65", 32'({err, in_ready, cpu_rst, busy, done}), 32'b10100);
    do_reset();
    send(8'h01);
    send(8'h01);
    chk("t3_257", 32'({err, in_ready, cpu_rst}), 32'b101);
    idle(2);
    chk("t3_we", 32'(wr_cnt), 32'd0);

`ifdef IMEM_BOOT_CHECKSUM_EN
    // Checksum good / bad
    do_reset();
    send(8'h00);
    send(8'h02);
    for (int b = 1; b <= 8; b++) send(8'(b));
    send(8'h24);
    idle(1);
    chk("t4_good", 32'({done, err, cpu_rst}), 32'b100);
    do_reset();
    send(8'h00);
    send(8'h02);
    for (int b = 1; b <= 8; b++) send(8'(b));
    send(8'h25);
    idle(1);
    chk("t4_bad", 32'({done, err, cpu_rst, in_ready}), 32'b0110);
    chk("t4_bad_cnt", 32'(wr_cnt), 32'd2);
    chk("t4_bad_w1", wr_data[1], 32'h05060708);
`endif

    // Reset mid-load
    do_reset();
    send(8'h00);
    send(8'h02);
    for (int b = 1; b <= 6; b++) send(8'(b));
    rst      = 1'b1;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("t5_abort", 32'({in_ready, busy, cpu_rst, imem_we, err}), 32'b10100);
    rst = 1'b0;
    idle(4);
    chk("t5_no_2nd", 32'(wr_cnt), 32'd1);
    wr_cnt = 0;
    csum   = 8'd0;
    send(8'h00);
    send(8'h01);
    send_pay(8'hAA);
    send_pay(8'hBB);
    send_pay(8'hCC);
    send_pay(8'hDD);
`ifdef IMEM_BOOT_CHECKSUM_EN
    send(csum);
`endif
    idle(2);
    chk("t5_cnt", 32'(wr_cnt), 32'd1);
    chk("t5_addr", 32'(wr_addr[0]), 32'd0);
    chk("t5_data", wr_data[0], 32'hAABBCCDD);
    chk("t5_done", 32'(done), 32'd1);

    // Gap-free vs random gaps
    load3(1'b0);
    load3(1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/imem_boot_loader.md
# imem_boot_loader

Serial boot loader that sits directly upstream of the instruction memory (64 × 32-bit words) and the MIPS core. It receives a byte stream over a valid/ready handshake and assembles the bytes into 32-bit instruction words. It writes each word into instruction memory through a dedicated write port and holds the core in reset until the whole program has been loaded. Loading at run time replaces rebuilding the memory-init file for every new program.

## Interface
Parameters:
- DEPTH, 64, number of instruction-memory words; legal word counts are 1..DEPTH
- AW, 6, instruction-memory word-address width; must satisfy 2^AW ≥ DEPTH

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  byte-source data valid
- in_data  in  8  stream byte
- in_ready  out  1  loader can accept a byte
- imem_we  out  1  instruction-memory write strobe, one cycle per word
- imem_addr  out  AW  word address, not byte address
- imem_wdata  out  32  assembled instruction word
- cpu_rst  out  1  reset to the core, active-high
- busy  out  1  a load is in progress
- done  out  1  program fully loaded, core released
- err  out  1  sticky load error

## Operation
- Byte transfer: a byte is accepted on a rising clk edge where in_valid & in_ready = 1. in_data must stay stable while in_valid=1 and in_ready=0.
- Stream format:
  - Two header bytes carry the word count N, big-endian 16-bit.
  - 4·N payload bytes follow, each word MSB first.
  - With CHECKSUM_EN, one checksum byte follows the payload.
- States:
  - HDR0: on accept, latch N[15:8] and go to HDR1.
  - HDR1: on accept, latch N[7:0]. If N==0 or N>DEPTH, go to ERR; otherwise go to DATA.
  - DATA: shift each accepted byte into a 32-bit assembly register. After the 4th byte of a word, write the word, increment the word index and clear the byte counter. After the 4th byte of word N-1, go to CSUM if CHECKSUM_EN is defined, else to FIN.
  - CSUM: on accept, compare the byte with the running sum. Match → FIN. Mismatch → ERR.
  - FIN: single cycle, then go to DONE.
  - DONE: terminal until rst.
  - ERR: terminal until rst.
- in_ready = 1 in HDR0, HDR1, DATA and CSUM; 0 in FIN, DONE and ERR.
- Write port:
  - imem_we, imem_addr and imem_wdata are registered.
  - imem_we pulses high for exactly one cycle, in the cycle after the 4th byte of a word is accepted.
  - imem_addr = word index 0..N-1; imem_wdata = {b0,b1,b2,b3}.
  - Byte acceptance is never stalled by a write; back-to-back bytes every cycle are supported.
- Status outputs:
  - cpu_rst = 1 in every state except DONE.
  - busy = 1 from the first accepted byte until entry to DONE or ERR.
  - done = 1 only in DONE.
  - err = 1 only in ERR.
- Words already written before an error are left in memory. The core stays in reset.
- Words at addresses ≥ N are never written.
- Header values ≥ 2^AW are range-checked on the full 16 bits and are never truncated.

## Timing
- Reset values, in the cycle after the rst edge: state=HDR0, in_ready=1, imem_we=0, imem_addr=0, imem_wdata=0, cpu_rst=1, busy=0, done=0, err=0. All counters and the checksum are cleared.
- rst mid-load aborts immediately: the state returns to HDR0, no further imem_we pulse is issued, and cpu_rst stays 1.
- Write latency: 4th byte accepted at edge k → imem_we=1 during cycle k..k+1.
- Final word:
  - Without CHECKSUM_EN: last byte at edge k → imem_we at cycle k (FIN), then DONE from edge k+1. cpu_rst falls at edge k+1, one cycle after the final write strobe.
  - With CHECKSUM_EN: the last word's write occurs during CSUM. Checksum byte at edge j → FIN in cycle j, DONE and cpu_rst=0 from edge j+1.
- Checksum arithmetic: 8-bit sum of all 4·N payload bytes, modulo 256. Header bytes are excluded.
- in_valid while in_ready=0 (FIN, DONE, ERR): ignored, no state change.

## Configuration
- IMEM_BOOT_CHECKSUM_EN:
  - Defined: the CSUM state, checksum accumulator and mismatch→ERR path are compiled in, and the stream carries a trailing checksum byte.
  - Undefined: these are compiled out, the stream ends after the payload, and err can only come from an illegal N.

## Test plan
- N=1, payload 20 08 00 05 (no checksum) → single imem_we at addr 0, wdata 0x20080005. cpu_rst falls the cycle after the strobe. done=1, err=0.
- N=64, bytes driven back-to-back with in_valid held high → 64 strobes, addr 0..63 in order, in_ready never drops before FIN. Final: done=1.
- Header 00 00, then separately header 00 41 (65) → err=1 after the 2nd byte, in_ready=0, cpu_rst=1, no imem_we.
- CHECKSUM_EN, N=2, payload 01 02 03 04 05 06 07 08: checksum 0x24 → done=1; checksum 0x25 → err=1 with both words written and cpu_rst held at 1.
- rst asserted after 6 of 8 payload bytes (N=2) → no second strobe, state back to HDR0. A fresh N=1 load then writes addr 0 correctly.
- Random gaps in in_valid, with in_data held while stalled → written words are identical to the gap-free run.
